// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command, status and pad bundle for the PS/2 host transmitter.
// The master side issues commands and models the pads; the slave side is the transmitter.
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       send;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       clk_oe;
  logic       dat_oe;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output data, send, ps2_clk, ps2_dat,
    input  clk_oe, dat_oe, busy, done, err
  );

  modport slave (
    input  data, send, ps2_clk, ps2_dat,
    output clk_oe, dat_oe, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command sender.
// Request-to-send, device-clocked 11-bit frame, ACK check and timeout.
module ps2_host_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);
  localparam int US   = CLK_HZ / 1_000_000;
  localparam int INH  = INHIBIT_US * US;
  localparam int TO   = TIMEOUT_MS * 1000 * US;
  localparam int CMAX = (INH > US) ? INH : US;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TO + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [3:0]    bidx, bidx_n;
  logic [10:0]   frame, frame_n;
  logic          err_f, err_n;
  logic [2:0]    ck_s;
  logic [1:0]    dt_s;
  logic          ck, dt, fall, tmo_hit;
  logic          clk_oe, dat_oe, done, err;

  assign ck      = ck_s[1];
  assign dt      = dt_s[1];
  assign fall    = ck_s[2] & ~ck_s[1];
  assign tmo_hit = (tmo == TW'(TO));

  // Synchronizers idle high so reset never looks like a clock fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_s  <= 3'b111;
      dt_s  <= 2'b11;
      state <= IDLE;
      cnt   <= '0;
      tmo   <= '0;
      bidx  <= '0;
      frame <= '0;
      err_f <= 1'b0;
    end else begin
      ck_s  <= {ck_s[1:0], bus.ps2_clk};
      dt_s  <= {dt_s[0], bus.ps2_dat};
      state <= state_n;
      cnt   <= cnt_n;
      tmo   <= tmo_n;
      bidx  <= bidx_n;
      frame <= frame_n;
      err_f <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tmo_n   = tmo;
    bidx_n  = bidx;
    frame_n = frame;
    err_n   = err_f;
    clk_oe  = 1'b0;
    dat_oe  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.send) begin
          frame_n = {1'b1, ~^bus.data, bus.data, 1'b0};
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe = 1'b1;
        if (cnt == CW'(INH - 1)) begin
          cnt_n   = '0;
          state_n = START;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      START: begin
        clk_oe = 1'b1;
        dat_oe = 1'b1;
        if (cnt == CW'(US - 1)) begin
          cnt_n   = '0;
          bidx_n  = '0;
          tmo_n   = '0;
          state_n = SEND;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND: begin
        dat_oe = ~frame[bidx];
        tmo_n  = tmo + 1'b1;
        if (tmo_hit) begin
          dat_oe  = 1'b0;
          done    = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          bidx_n = bidx + 1'b1;
          if (bidx == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        tmo_n = tmo + 1'b1;
        if (tmo_hit) begin
          done    = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          err_n   = dt;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        tmo_n = tmo + 1'b1;
        if (tmo_hit) begin
          done    = 1'b1;
          err     = 1'b1;
          state_n = IDLE;
        end else if (ck && dt) begin
          done    = 1'b1;
          err     = err_f;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.clk_oe = clk_oe;
  assign bus.dat_oe = dat_oe;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done;
  assign bus.err    = err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model on open-drain pads driving the host sender.
// Directed table plus random commands checked against a frame-level model.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO  = 2000;

  typedef struct {
    logic [7:0] d;
    int         mode;
    bit         rep;
    logic [9:0] bits;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  vec_t tbl[8];

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .CLK_HZ(1_000_000),
    .INHIBIT_US(100),
    .TIMEOUT_MS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.ps2_clk = ~(bus.clk_oe | dev_clk_low);
  assign bus.ps2_dat = ~(bus.dat_oe | dev_dat_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bits the device should see on its rising edges: d0..d7, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic [9:0] r;
    for (int i = 0; i < 8; i++) r[i] = ((d >> i) & 8'd1) != 0;
    r[8] = ($countones(d) % 2) == 0;
    r[9] = 1'b1;
    return r;
  endfunction

  // mode: 0 ack, 1 nack, 2 silent device, 3 reset after fall 5
  task automatic run_frame(input logic [7:0] d, input int mode, input bit rep,
                           input logic [9:0] exp_bits, input logic exp_err,
                           input string tag);
    int n;
    int rel;
    int dc0;
    logic [9:0] got;
    got = '0;
    dc0 = done_cnt;
    @(negedge clk);
    bus.data = d;
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    bus.data = 8'($urandom);
    chk({tag, " busy"}, bus.busy, 1);
    n = 0;
    while (bus.clk_oe && !bus.dat_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " inhibit"}, n, INH);
    n = 0;
    while (bus.clk_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " start"}, {bus.clk_oe, bus.dat_oe}, 2'b01);
    rel = cyc;
    if (mode == 2) begin
      n = 0;
      while (!bus.done && n < TO + 100) begin
        n++;
        @(negedge clk);
      end
      chk({tag, " tmo cycles"}, cyc - rel, TO);
      chk({tag, " tmo err"}, {bus.done, bus.err}, 2'b11);
      chk({tag, " tmo oe"}, {bus.clk_oe, bus.dat_oe}, 0);
      repeat (5) @(negedge clk);
      chk({tag, " one done"}, done_cnt - dc0, 1);
      return;
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      if (mode == 3 && i == 4) begin
        #3 rst = 1'b1;
        #1 chk({tag, " rst oe"}, {bus.clk_oe, bus.dat_oe, bus.busy}, 0);
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk({tag, " rst no done"}, done_cnt - dc0, 0);
        return;
      end
      if (rep && i == 3) begin
        bus.data = ~d;
        bus.send = 1'b1;
      end
      @(negedge clk);
      bus.send = 1'b0;
      repeat (9) @(negedge clk);
      dev_clk_low = 1'b0;
      got[i] = bus.ps2_dat;
      repeat (20) @(negedge clk);
    end
    chk({tag, " frame"}, got, exp_bits);
    repeat (5) @(negedge clk);
    dev_dat_low = (mode == 0);
    repeat (15) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin
      if (n == 5) dev_dat_low = 1'b0;
      n++;
      @(negedge clk);
    end
    dev_dat_low = 1'b0;
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " err"}, bus.err, exp_err);
    @(negedge clk);
    chk({tag, " idle"}, {bus.clk_oe, bus.dat_oe, bus.busy}, 0);
    repeat (5) @(negedge clk);
    chk({tag, " one done"}, done_cnt - dc0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int m;
    tbl[0] = '{8'hED, 0, 1'b0, 10'h3ED, 1'b0};
    tbl[1] = '{8'h01, 0, 1'b0, 10'h201, 1'b0};
    tbl[2] = '{8'hFF, 0, 1'b0, 10'h3FF, 1'b0};
    tbl[3] = '{8'h55, 1, 1'b0, 10'h355, 1'b1};
    tbl[4] = '{8'h3C, 0, 1'b1, 10'h33C, 1'b0};
    tbl[5] = '{8'h12, 2, 1'b0, 10'h000, 1'b1};
    tbl[6] = '{8'hAA, 3, 1'b0, 10'h000, 1'b0};
    tbl[7] = '{8'hF4, 0, 1'b0, 10'h2F4, 1'b0};
    bus.data = 8'h00;
    bus.send = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst clk_oe", bus.clk_oe, 0);
    chk("rst dat_oe", bus.dat_oe, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst err", bus.err, 0);
    for (int k = 0; k < 8; k++) begin
      run_frame(tbl[k].d, tbl[k].mode, tbl[k].rep, tbl[k].bits,
                tbl[k].err, $sformatf("vec%0d", k));
    end
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      m = $urandom_range(0, 1);
      run_frame(d, m, 1'b0, ref_frame(d), (m == 1),
                $sformatf("rnd%0d_%02h", k, d));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
